// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Sequencer between the pipeline commit stage and the machine-mode CSR file.
//   Detects synchronous exceptions, mret and pending machine interrupts,
//   drains the pipeline, issues the single-cycle mepc/mcause write and
//   mstatus.MIE clear/restore strobes, then hands a redirect PC to fetch.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_exc_valid/cause/pc  synchronous exception from commit
//   i_mret                committing instruction is mret
//   i_irq_pc              PC saved when an interrupt is taken
//   i_halted              debug mode: no new events are accepted in IDLE
//   i_mtvec/mepc/mie/mip  live CSR values
//   i_mstatus_mie         global machine interrupt enable
//   o_flush, i_drain_done pipeline kill request / pipeline empty
//   o_mepc_*/o_mcause_*   CSR write data and strobes (COMMIT only)
//   o_mie_clear/restore   mstatus MIE stack strobes (COMMIT only)
//   o_redirect_*          redirect to fetch, valid/ready handshake
//   o_busy                sequencer not in IDLE
//   o_state_dbg           current FSM state (IDLE=0, DRAIN=1, COMMIT=2, REDIRECT=3)
//
// Redirect handshake: o_redirect_valid rises when REDIRECT is entered and
// stays high, with o_redirect_pc unchanged, until a cycle where
// i_redirect_ready is also high; that cycle is the transfer, and valid is low
// in the following cycle.
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter bit          VECTORED_EN = 1'b1,
  parameter int unsigned DRAIN_MAX   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_exc_valid,
  input  logic [5:0]  i_exc_cause,
  input  logic [63:0] i_exc_pc,
  input  logic        i_mret,
  input  logic [63:0] i_irq_pc,
  input  logic        i_halted,
  input  logic [63:0] i_mtvec,
  input  logic [63:0] i_mepc,
  input  logic [63:0] i_mie,
  input  logic [63:0] i_mip,
  input  logic        i_mstatus_mie,
  output logic        o_flush,
  input  logic        i_drain_done,
  output logic [63:0] o_mepc_data,
  output logic        o_mepc_we,
  output logic [63:0] o_mcause_data,
  output logic        o_mcause_we,
  output logic        o_mie_clear,
  output logic        o_mie_restore,
  output logic        o_redirect_valid,
  output logic [63:0] o_redirect_pc,
  input  logic        i_redirect_ready,
  output logic        o_busy,
  output logic [1:0]  o_state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

  state_e      state_q, state_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] cause_q, cause_d;
  logic [3:0]  code_q, code_d;
  logic        kind_ret_q, kind_ret_d;   // 1 = mret sequence, 0 = trap
  logic [63:0] redirect_pc_q, redirect_pc_d;

  // Registered outputs and their next values
  logic        flush_q, flush_d;
  logic [63:0] mepc_data_q, mepc_data_d;
  logic        mepc_we_q, mepc_we_d;
  logic [63:0] mcause_data_q, mcause_data_d;
  logic        mcause_we_q, mcause_we_d;
  logic        mie_clear_q, mie_clear_d;
  logic        mie_restore_q, mie_restore_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic        busy_q, busy_d;

  // ---------------------------------------------------------------------------
  // Event detection (only consulted in IDLE)
  // ---------------------------------------------------------------------------
  logic [63:0] irq_bits;
  logic        irq_any;
  logic [3:0]  irq_code;
  logic        event_take;

  always_comb begin
    irq_bits = i_mie & i_mip;
    irq_any  = i_mstatus_mie & (irq_bits[11] | irq_bits[3] | irq_bits[7]);
    // Priority MEI(11) > MSI(3) > MTI(7)
    if (irq_bits[11])     irq_code = 4'd11;
    else if (irq_bits[3]) irq_code = 4'd3;
    else                  irq_code = 4'd7;
    event_take = !i_halted && (i_exc_valid || i_mret || irq_any);
  end

  // ---------------------------------------------------------------------------
  // Redirect target, evaluated from live CSRs while in COMMIT
  // ---------------------------------------------------------------------------
  logic [63:0] vec_base;
  logic [63:0] target_pc;

  always_comb begin
    vec_base = {i_mtvec[63:2], 2'b00};
    if (kind_ret_q) begin
      target_pc = i_mepc;
    end else if (VECTORED_EN && cause_q[63] && (i_mtvec[1:0] == 2'b01)) begin
      target_pc = vec_base + {58'h0, code_q, 2'b00};
    end else begin
      target_pc = vec_base;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      drain_cnt_q   <= 8'd0;
      pc_q          <= 64'd0;
      cause_q       <= 64'd0;
      code_q        <= 4'd0;
      kind_ret_q    <= 1'b0;
      redirect_pc_q <= 64'd0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      pc_q          <= pc_d;
      cause_q       <= cause_d;
      code_q        <= code_d;
      kind_ret_q    <= kind_ret_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    pc_d          = pc_q;
    cause_d       = cause_q;
    code_d        = code_q;
    kind_ret_d    = kind_ret_q;
    redirect_pc_d = redirect_pc_q;

    unique case (state_q)
      S_IDLE: begin
        drain_cnt_d = 8'd0;
        if (event_take) begin
          state_d = S_DRAIN;
          if (i_exc_valid) begin
            pc_d       = i_exc_pc;
            cause_d    = {1'b0, 57'h0, i_exc_cause};
            kind_ret_d = 1'b0;
          end else if (i_mret) begin
            kind_ret_d = 1'b1;
          end else begin
            pc_d       = i_irq_pc;
            cause_d    = {1'b1, 59'h0, irq_code};
            code_d     = irq_code;
            kind_ret_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 8'd1;
        // Timeout bounds the time spent waiting on a pipeline that never empties
        if (i_drain_done || (drain_cnt_q == DRAIN_LAST)) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        redirect_pc_d = target_pc;
        state_d       = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (i_redirect_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values derived from the next state, so every output
  // comes straight from a flop. COMMIT is only ever entered from DRAIN, so the
  // latched kind/pc/cause are already valid when state_d is COMMIT.
  // ---------------------------------------------------------------------------
  always_comb begin
    flush_d          = (state_d == S_DRAIN) || (state_d == S_COMMIT);
    mepc_we_d        = 1'b0;
    mcause_we_d      = 1'b0;
    mie_clear_d      = 1'b0;
    mie_restore_d    = 1'b0;
    mepc_data_d      = 64'd0;
    mcause_data_d    = 64'd0;
    redirect_valid_d = (state_d == S_REDIRECT);
    busy_d           = (state_d != S_IDLE);
    if (state_d == S_COMMIT) begin
      if (kind_ret_q) begin
        mie_restore_d = 1'b1;
      end else begin
        mepc_we_d     = 1'b1;
        mcause_we_d   = 1'b1;
        mie_clear_d   = 1'b1;
        mepc_data_d   = {pc_q[63:1], 1'b0};
        mcause_data_d = cause_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      flush_q          <= 1'b0;
      mepc_data_q      <= 64'd0;
      mepc_we_q        <= 1'b0;
      mcause_data_q    <= 64'd0;
      mcause_we_q      <= 1'b0;
      mie_clear_q      <= 1'b0;
      mie_restore_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      flush_q          <= flush_d;
      mepc_data_q      <= mepc_data_d;
      mepc_we_q        <= mepc_we_d;
      mcause_data_q    <= mcause_data_d;
      mcause_we_q      <= mcause_we_d;
      mie_clear_q      <= mie_clear_d;
      mie_restore_q    <= mie_restore_d;
      redirect_valid_q <= redirect_valid_d;
      busy_q           <= busy_d;
    end
  end

  assign o_flush          = flush_q;
  assign o_mepc_data      = mepc_data_q;
  assign o_mepc_we        = mepc_we_q;
  assign o_mcause_data    = mcause_data_q;
  assign o_mcause_we      = mcause_we_q;
  assign o_mie_clear      = mie_clear_q;
  assign o_mie_restore    = mie_restore_q;
  assign o_redirect_valid = redirect_valid_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_busy           = busy_q;
  assign o_state_dbg      = state_q;

  // Only MEI/MSI/MTI participate; the remaining interrupt bits and mepc bit 0
  // are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{irq_bits[63:12], irq_bits[10:8], irq_bits[6:4],
                         irq_bits[2:0], pc_q[0]};

endmodule
